// File: rtl/pixie_pkg.sv
// Shared constants and types for the Pixie raster back end.
// Defaults are the 1861 NTSC timing set.
package pixie_pkg;

    localparam int PIX_H_TOTAL      = 112;
    localparam int PIX_H_START      = 0;
    localparam int PIX_H_ACTIVE     = 64;
    localparam int PIX_H_SYNC_START = 80;
    localparam int PIX_H_SYNC_WIDTH = 12;
    localparam int PIX_V_TOTAL      = 262;
    localparam int PIX_V_START      = 64;
    localparam int PIX_V_ACTIVE     = 128;
    localparam int PIX_V_SYNC_START = 0;
    localparam int PIX_V_SYNC_WIDTH = 16;
    localparam int PIX_V_SCALE      = 4;
    localparam int PIX_ADDR_W       = 10;
    localparam int PIX_COL_W        = 3;
    localparam int POS_W            = 16;

    typedef struct packed {
        logic [POS_W-1:0] h;
        logic [POS_W-1:0] v;
    } frame_pos_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblank;
        logic vblank;
        logic de;
        logic frame_start;
    } raster_flags_t;

    // Window test by unsigned offset, so a start of 0 needs no special case.
    function automatic logic in_span(input logic [POS_W-1:0] x, input int start, input int len);
        logic [POS_W-1:0] rel;
        rel = x - POS_W'(start);
        return rel < POS_W'(len);
    endfunction

endpackage

// File: rtl/pixie_raster_timing.sv
// Horizontal/vertical counters with window, sync and frame-start decode.
// All decoded flags describe the current counter position (pre-pipeline).
module pixie_raster_timing
    import pixie_pkg::*;
#(
    parameter int H_TOTAL      = PIX_H_TOTAL,
    parameter int H_START      = PIX_H_START,
    parameter int H_ACTIVE     = PIX_H_ACTIVE,
    parameter int H_SYNC_START = PIX_H_SYNC_START,
    parameter int H_SYNC_WIDTH = PIX_H_SYNC_WIDTH,
    parameter int V_TOTAL      = PIX_V_TOTAL,
    parameter int V_START      = PIX_V_START,
    parameter int V_ACTIVE     = PIX_V_ACTIVE,
    parameter int V_SYNC_START = PIX_V_SYNC_START,
    parameter int V_SYNC_WIDTH = PIX_V_SYNC_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    output logic [POS_W-1:0] h_o,
    output logic             line_end_o,
    output logic             frame_end_o,
    output logic             h_act_o,
    output logic             v_act_o,
    output raster_flags_t    flags_o
);

    frame_pos_t pos_q, pos_d;

    assign line_end_o  = (pos_q.h == POS_W'(H_TOTAL - 1));
    assign frame_end_o = line_end_o && (pos_q.v == POS_W'(V_TOTAL - 1));

    always_comb begin
        pos_d = pos_q;
        if (line_end_o) begin
            pos_d.h = '0;
            pos_d.v = frame_end_o ? '0 : pos_q.v + POS_W'(1);
        end else begin
            pos_d.h = pos_q.h + POS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign h_o     = pos_q.h;
    assign h_act_o = in_span(pos_q.h, H_START, H_ACTIVE);
    assign v_act_o = in_span(pos_q.v, V_START, V_ACTIVE);

    always_comb begin
        flags_o.hsync       = in_span(pos_q.h, H_SYNC_START, H_SYNC_WIDTH);
        flags_o.vsync       = in_span(pos_q.v, V_SYNC_START, V_SYNC_WIDTH);
        flags_o.hblank      = !h_act_o;
        flags_o.vblank      = !v_act_o;
        flags_o.de          = h_act_o && v_act_o;
        flags_o.frame_start = (pos_q.h == '0) && (pos_q.v == '0);
    end

endmodule

// File: rtl/pixie_video_gen.sv
// Raster back end: bitmap fetch, line replication, MSB-first shifter and a
// two-stage output pipeline keeping sync/blank aligned with the pixel path.
module pixie_video_gen
    import pixie_pkg::*;
#(
    parameter int H_TOTAL      = PIX_H_TOTAL,
    parameter int H_START      = PIX_H_START,
    parameter int H_ACTIVE     = PIX_H_ACTIVE,
    parameter int H_SYNC_START = PIX_H_SYNC_START,
    parameter int H_SYNC_WIDTH = PIX_H_SYNC_WIDTH,
    parameter int V_TOTAL      = PIX_V_TOTAL,
    parameter int V_START      = PIX_V_START,
    parameter int V_ACTIVE     = PIX_V_ACTIVE,
    parameter int V_SYNC_START = PIX_V_SYNC_START,
    parameter int V_SYNC_WIDTH = PIX_V_SYNC_WIDTH,
    parameter int V_SCALE      = PIX_V_SCALE,
    parameter int ADDR_W       = PIX_ADDR_W,
    parameter int COLOUR       = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 display_on,
    input  logic [PIX_COL_W-1:0] bg_colour,
    output logic                 fb_read_en,
    output logic [ADDR_W-1:0]    fb_addr,
    input  logic [7:0]           fb_data,
    output logic [ADDR_W-1:0]    col_addr,
    input  logic [PIX_COL_W-1:0] col_data,
    output logic                 video,
    output logic [PIX_COL_W-1:0] rgb,
    output logic                 HSync,
    output logic                 VSync,
    output logic                 csync,
    output logic                 HBlank,
    output logic                 VBlank,
    output logic                 video_de,
    output logic                 frame_start
);

    logic [POS_W-1:0] h;
    logic             line_end, frame_end, h_act, v_act;
    raster_flags_t    flags, flags_q1, flags_q2;

    pixie_raster_timing #(
        .H_TOTAL(H_TOTAL), .H_START(H_START), .H_ACTIVE(H_ACTIVE),
        .H_SYNC_START(H_SYNC_START), .H_SYNC_WIDTH(H_SYNC_WIDTH),
        .V_TOTAL(V_TOTAL), .V_START(V_START), .V_ACTIVE(V_ACTIVE),
        .V_SYNC_START(V_SYNC_START), .V_SYNC_WIDTH(V_SYNC_WIDTH)
    ) u_timing (
        .clk(clk), .reset(reset), .h_o(h), .line_end_o(line_end),
        .frame_end_o(frame_end), .h_act_o(h_act), .v_act_o(v_act), .flags_o(flags)
    );

    logic                 disp_en_q;
    logic [ADDR_W-1:0]    row_base_q, row_base_d;
    logic [2:0]           rep_cnt_q, rep_cnt_d;
    logic                 fetch, fetch_q;
    logic [7:0]           shift_q, shift_d;
    logic [PIX_COL_W-1:0] colour_q, colour_d;
    logic [ADDR_W-1:0]    byte_col;
    logic [2:0]           byte_bit;

    assign byte_col = ADDR_W'((h - POS_W'(H_START)) >> 3);
    assign byte_bit = 3'(h - POS_W'(H_START));

    // Frame-buffer read: fb_read_en/fb_addr are a one-cycle request with no
    // back-pressure; fb_data/col_data must be valid exactly one clk later.
    assign fetch      = disp_en_q && h_act && v_act && (byte_bit == 3'd0);
    assign fb_read_en = fetch;
    assign fb_addr    = fetch ? row_base_q + byte_col : '0;
    assign col_addr   = fb_addr;

    always_comb begin
        row_base_d = row_base_q;
        rep_cnt_d  = rep_cnt_q;
        if (frame_end) begin
            row_base_d = '0;
            rep_cnt_d  = '0;
        end else if (line_end && v_act) begin
            if (rep_cnt_q == 3'(V_SCALE - 1)) begin
                row_base_d = row_base_q + ADDR_W'(H_ACTIVE / 8);
                rep_cnt_d  = '0;
            end else begin
                rep_cnt_d = rep_cnt_q + 3'd1;
            end
        end
    end

    always_comb begin
        shift_d  = {shift_q[6:0], 1'b0};
        colour_d = colour_q;
        if (!disp_en_q) begin
            shift_d = '0;
        end else if (fetch_q) begin
            shift_d  = fb_data;
            colour_d = col_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_en_q  <= 1'b0;
            row_base_q <= '0;
            rep_cnt_q  <= '0;
            fetch_q    <= 1'b0;
            shift_q    <= '0;
            colour_q   <= '0;
            flags_q1   <= '0;
            flags_q2   <= '0;
        end else begin
            if (frame_end) begin
                disp_en_q <= display_on;
            end
            row_base_q <= row_base_d;
            rep_cnt_q  <= rep_cnt_d;
            fetch_q    <= fetch;
            shift_q    <= shift_d;
            colour_q   <= colour_d;
            flags_q1   <= flags;
            flags_q2   <= flags_q1;
        end
    end

    assign video = shift_q[7] && flags_q2.de;

    always_comb begin
        if (COLOUR != 0) begin
            rgb = flags_q2.de ? (video ? colour_q : bg_colour) : '0;
        end else begin
            rgb = {PIX_COL_W{video}};
        end
    end

    assign HSync       = flags_q2.hsync;
    assign VSync       = flags_q2.vsync;
    assign csync       = flags_q2.hsync ^ flags_q2.vsync;
    assign HBlank      = flags_q2.hblank;
    assign VBlank      = flags_q2.vblank;
    assign video_de    = flags_q2.de;
    assign frame_start = flags_q2.frame_start;

endmodule

// File: doc/pixie_video_gen.md
# pixie_video_gen

Parametrised raster back end for the Pixie-family display path. It generates horizontal/vertical timing, fetches bitmap bytes from the dual-port frame buffer, serialises them MSB-first and drives mono or 3-bit colour pixels with aligned sync, blank and data-enable. Compared with the fixed single-mode back end, it adds:

- a positionable active window;
- vertical line replication;
- a frame-latched display enable;
- a colour-RAM lookup mode;
- correct blanking outputs;
- a frame-start strobe for the CPU side (EF/interrupt logic).

## Interface
Parameters:
- `H_TOTAL`, 112: pixel clocks per line.
- `H_START`, 0: first active pixel; multiple of 8.
- `H_ACTIVE`, 64: active pixels per line; multiple of 8.
- `H_SYNC_START`, 80: first HSync pixel.
- `H_SYNC_WIDTH`, 12: HSync length in pixels.
- `V_TOTAL`, 262: lines per frame.
- `V_START`, 64: first active line.
- `V_ACTIVE`, 128: active display lines.
- `V_SYNC_START`, 0: first VSync line.
- `V_SYNC_WIDTH`, 16: VSync length in lines.
- `V_SCALE`, 4: output lines per bitmap row; range 1..8.
- `ADDR_W`, 10: frame-buffer address width.
- `COLOUR`, 0: 0 selects mono, 1 selects colour-RAM mode.

Ports:
- `clk`  in  1  pixel clock.
- `reset`  in  1  reset. One clock; reset is synchronous and active-high.
- `display_on`  in  1  display enable request; sampled once per frame.
- `bg_colour`  in  3  colour used for clear pixels in colour mode.
- `fb_read_en`  out  1  frame-buffer read strobe.
- `fb_addr`  out  ADDR_W  byte address.
- `fb_data`  in  8  bitmap byte; valid 1 clk after `fb_read_en`.
- `col_addr`  out  ADDR_W  colour-RAM address; equals `fb_addr`.
- `col_data`  in  3  colour byte; valid 1 clk after `fb_read_en`.
- `video`  out  1  mono pixel.
- `rgb`  out  3  colour pixel.
- `HSync`, `VSync`  out  1  active-high syncs.
- `csync`  out  1  HSync XOR VSync.
- `HBlank`, `VBlank`  out  1  asserted outside the active window.
- `video_de`  out  1  equals NOT HBlank AND NOT VBlank.
- `frame_start`  out  1  one-clk pulse at h=0, v=0.

## Operation
- Counters:
  - `h` counts 0..H_TOTAL-1 and wraps to 0.
  - `v` increments when `h` wraps; it counts 0..V_TOTAL-1 and wraps to 0.
- Active window: `h` in [H_START, H_START+H_ACTIVE) and `v` in [V_START, V_START+V_ACTIVE).
- Sync windows: HSync asserts when `h` is in [H_SYNC_START, +H_SYNC_WIDTH). VSync asserts when `v` is in [V_SYNC_START, +V_SYNC_WIDTH).
- Display-enable latch `disp_en`: loads `display_on` only on the cycle where h=H_TOTAL-1 and v=V_TOTAL-1. Changes mid-frame have no effect until the next frame.
- Fetch:
  - Condition: `disp_en`, active window, and (h-H_START)[2:0]=0.
  - Action: `fb_read_en`=1 and `fb_addr` = `row_base` + (h-H_START)/8.
  - No reads occur outside these conditions.
- Row stepping:
  - `rep_cnt` counts active lines 0..V_SCALE-1.
  - At the end of each active line where `rep_cnt`=V_SCALE-1, `row_base` += H_ACTIVE/8 and `rep_cnt` returns to 0.
  - Both `row_base` and `rep_cnt` clear at frame wrap.
  - `row_base` wraps modulo 2^ADDR_W.
- Shifter:
  - Loads `fb_data` (and latches `col_data`) on the cycle after a fetch; otherwise it shifts left, filling with 0.
  - When `disp_en`=0, the shifter loads 0, so blank pixels are output while `video_de` stays valid.
- Pixel out:
  - `video` = shifter[7] AND `video_de`.
  - `rgb`: COLOUR=1 gives `video` ? latched colour : `bg_colour` when `video_de`, else 0. COLOUR=0 gives {3{`video`}}.

## Timing
- Output latency is 2 clks.
- Every registered output at cycle t describes counter position (h,v) from cycle t-2. Sync, blank, `video_de` and `frame_start` are delayed to match the pixel path.
- Bit 7 of the byte fetched at h=H_START+8k appears on `video` at counter position h+2. Bits 6..0 follow on consecutive clks.
- Reset:
  - All counters, `row_base`, `rep_cnt`, `disp_en`, shifter and pipeline registers clear to 0.
  - All outputs are 0 in the cycle after reset is sampled.
  - Reset asserted mid-line restarts cleanly at h=0, v=0 with no residual fetch or pixel.
- Simultaneous line and frame wrap: the frame wrap takes priority, so `row_base`=0 and `rep_cnt`=0.

## Structure
- `pixie_pkg` holds the default timing constants (1861 NTSC set), colour width `PIX_COL_W`=3 and a `frame_pos_t` struct {h,v}.
- Sub-module `pixie_raster_timing` holds the h/v counters, window and sync decode, and the `frame_start` pre-pipeline signals. `pixie_video_gen` instantiates it and adds fetch, row stepping, shifter and the output pipeline.

## Test plan
- Defaults, reset then 2 frames: HSync is 12 clks every 112; VSync is 16 lines every 262; `frame_start` pulses once per 29344 clks.
- Mono pattern: byte at addr 0 = 0xA5 and `display_on`=1 → first active line outputs `video` 1,0,1,0,0,1,0,1. `fb_addr` sequence is 0..7 on lines 64..67 and 8..15 on line 68.
- V_SCALE=1, V_ACTIVE=32: `fb_addr` advances by 8 every line; the last row addresses 248..255, then wraps to 0 at the frame.
- `display_on` toggled mid-frame: no change until the next frame. Once disabled, `fb_read_en` stays 0 and `video` is 0 while `video_de` keeps toggling.
- COLOUR=1: `fb_data`=0xF0, `col_data`=3'b010, `bg_colour`=3'b001 → `rgb` is 010×4 then 001×4. `rgb` is 0 during blank.
- Reset pulsed at h=50, v=70 → the next cycle has all outputs at 0, and the frame restarts from h=0, v=0.
